// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one execute ALU between NREQ requesters, one op in flight.
// Optional per-requester saturating grant counters when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int OPW  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic [NREQ*OPW-1:0]  req_op,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [DW-1:0]        rsp_data,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic [OPW-1:0]       alu_op,
  input  logic [DW-1:0]        alu_res,
  output logic [NREQ*16-1:0]   grant_cnt
);

  localparam int GW = $clog2(NREQ);
  localparam logic [GW:0] NREQ_W = (GW+1)'(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   last_gnt_reg, gnt_reg, win;
  logic            win_found;
  logic            accept;
  logic [GW:0]     cand;
  logic [NREQ-1:0] gnt_onehot;
  logic [NREQ-1:0] rsp_valid_reg;
  logic [DW-1:0]   rsp_data_reg, alu_a_reg, alu_b_reg;
  logic [OPW-1:0]  alu_op_reg;

  // Search starts one past the last grant and wraps, so the most recent winner ranks last.
  always_comb begin
    win       = last_gnt_reg;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_gnt_reg} + (GW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!win_found && req_valid[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win       = cand[GW-1:0];
      end
    end
  end

  assign gnt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << gnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // req_ready is gated by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found && rst_n) begin
          req_ready[win] = 1'b1;
          accept         = 1'b1;
          state_next     = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready[gnt_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_reg  <= GW'(NREQ-1);
      gnt_reg       <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_op_reg    <= '0;
      rsp_data_reg  <= '0;
      rsp_valid_reg <= '0;
    end else begin
      if (accept) begin
        alu_a_reg    <= req_a[win*DW +: DW];
        alu_b_reg    <= req_b[win*DW +: DW];
        alu_op_reg   <= req_op[win*OPW +: OPW];
        gnt_reg      <= win;
        last_gnt_reg <= win;
      end
      if (state_reg == EXEC) begin
        rsp_data_reg  <= alu_res;
        rsp_valid_reg <= gnt_onehot;
      end
      if (state_reg == RESP && rsp_ready[gnt_reg]) rsp_valid_reg <= '0;
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = alu_op_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_valid = rsp_valid_reg;

`ifdef ALU_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
      logic [15:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt_reg <= '0;
        else if (accept && win == GW'(gi) && cnt_reg != 16'hFFFF)
          cnt_reg <= cnt_reg + 16'd1;
      end
      assign grant_cnt[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level model plus per-cycle compare and literal pins.
module tb_alu_arbiter;

  localparam int N = 2;
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_AND = 6'd2;
  localparam logic [5:0] ALU_OR  = 6'd3;
  localparam logic [5:0] ALU_XOR = 6'd4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0]   req_a, req_b;
  logic [11:0]   req_op;
  logic [31:0]   rsp_data, alu_a, alu_b, alu_res;
  logic [5:0]    alu_op;
  logic [31:0]   grant_cnt;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.NREQ(N), .DW(32), .OPW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  // Unknown op codes do something distinctive so pass-through is visible.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return {a[15:0], b[15:0]};
    endcase
  endfunction

  assign alu_res = alu_f(alu_a, alu_b, alu_op);

  // Valid requester with the smallest forward distance from the pointer wins.
  function automatic int rr_pick(input logic [1:0] v, input int ptr);
    int best, bestd, d;
    best = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - ptr - 1 + 2*N) % N;
        if (d < bestd) begin
          bestd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Transaction model: busy flag plus cycle age of the op in flight.
  logic        m_busy;
  int          m_age, m_gnt, m_ptr, m_win;
  logic [31:0] m_data, m_a, m_b;
  logic [5:0]  m_op;
  int          m_cnt [2];

  assign m_win = rr_pick(req_valid, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_age <= 0; m_gnt <= 0; m_ptr <= N-1;
      m_data <= '0; m_a <= '0; m_b <= '0; m_op <= '0;
      m_cnt[0] <= 0; m_cnt[1] <= 0;
    end else if (m_busy) begin
      if (m_age >= 2 && rsp_ready[m_gnt]) m_busy <= 1'b0;
      else m_age <= m_age + 1;
    end else if (m_win >= 0) begin
      m_busy <= 1'b1;
      m_age  <= 1;
      m_gnt  <= m_win;
      m_ptr  <= m_win;
      m_a    <= req_a[m_win*32 +: 32];
      m_b    <= req_b[m_win*32 +: 32];
      m_op   <= req_op[m_win*6 +: 6];
      m_data <= alu_f(req_a[m_win*32 +: 32], req_b[m_win*32 +: 32], req_op[m_win*6 +: 6]);
      if (m_cnt[m_win] < 65535) m_cnt[m_win] <= m_cnt[m_win] + 1;
    end
  end

  always @(negedge clk) begin
    check("cmp_req_ready", req_ready, (rst_n && !m_busy && m_win >= 0) ? (64'd1 << m_win) : 64'd0);
    check("cmp_rsp_valid", rsp_valid, (m_busy && m_age >= 2) ? (64'd1 << m_gnt) : 64'd0);
    if (m_busy && m_age >= 2) check("cmp_rsp_data", rsp_data, m_data);
    if (!rst_n) check("cmp_rsp_data_rst", rsp_data, 0);
    check("cmp_alu_a", alu_a, m_a);
    check("cmp_alu_b", alu_b, m_b);
    check("cmp_alu_op", alu_op, m_op);
`ifdef ALU_ARB_STATS_EN
    check("cmp_grant_cnt", grant_cnt, {16'(m_cnt[1]), 16'(m_cnt[0])});
`else
    check("cmp_grant_cnt", grant_cnt, 0);
`endif
    if (rst_n && m_busy && m_age >= 2 && rsp_ready[m_gnt])
      $display("txn %0t req%0d op=%0d a=%h b=%h data=%h", $time, m_gnt, m_op, m_a, m_b, rsp_data);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic setreq(input int i, input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*6 +: 6]  = op;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] seq;
  int ng;

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_op = '0;
    setreq(0, 32'd1, 32'd1, ALU_ADD);
    setreq(1, 32'd2, 32'd2, ALU_ADD);
    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_alu_a", alu_a, 0);
    end
    step();
    rst_n = 1'b1; req_valid = 2'b00;

    // Single subtract on requester 0
    step();
    setreq(0, 32'd5, 32'd3, ALU_SUB); req_valid = 2'b01; rsp_ready = 2'b01;
    @(negedge clk); check("single_rdy", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    @(negedge clk); check("single_c1_valid", rsp_valid, 0);
    @(negedge clk); check("single_c2_valid", rsp_valid, 2'b01);
    check("single_data", rsp_data, 32'd2);
    step();

    // Fairness with both requesters held valid
    do_reset();
    setreq(0, 32'h12345678, 32'h9ABCDEF0, 6'h2A);
    setreq(1, 32'hFFFFFFFF, 32'h00000001, ALU_ADD);
    req_valid = 2'b11; rsp_ready = 2'b11;
    seq = '0; ng = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        seq = {seq[2:0], req_ready[1]};
        ng++;
      end
      if (rsp_valid == 2'b10) check("fair_add_wrap", rsp_data, 32'h0);
      if (rsp_valid == 2'b01) check("fair_passthru", rsp_data, 32'h5678DEF0);
    end
    check("fair_ngrants", ng, 4);
    check("fair_order", seq, 4'b0101);
    step(); req_valid = 2'b00;

    // Backpressure on requester 0; requester 1 waits
    setreq(0, 32'h0000F0F0, 32'h0000FF00, ALU_AND);
    setreq(1, 32'h0F0F0F0F, 32'hFFFF0000, ALU_XOR);
    req_valid = 2'b11; rsp_ready = 2'b00;
    @(negedge clk); check("bp_rdy", req_ready, 2'b01);
    step();
    step(); rsp_ready = 2'b10;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_hold", rsp_valid, 2'b01);
      check("bp_data_hold", rsp_data, 32'h0000F000);
      check("bp_no_rdy", req_ready, 0);
    end
    step(); rsp_ready = 2'b01;
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 2'b01);
    check("bp_wait_idle", req_ready, 0);
    step();
    @(negedge clk); check("bp_next_rdy", req_ready, 2'b10);
    step(); req_valid = 2'b00; rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("bp_xor_valid", rsp_valid, 2'b10);
    check("bp_xor_data", rsp_data, 32'hF0F00F0F);
    step();

    // Reset while an op is in EXEC
    setreq(1, 32'd7, 32'd9, ALU_OR); req_valid = 2'b10; rsp_ready = 2'b11;
    @(negedge clk); check("mid_rdy", req_ready, 2'b10);
    step(); rst_n = 1'b0; req_valid = 2'b11;
    @(negedge clk); check("mid_rst_valid", rsp_valid, 0);
    step();
    @(negedge clk); check("mid_rst_valid2", rsp_valid, 0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    check("mid_first_gnt", req_ready, 2'b01);
    check("mid_no_pulse", rsp_valid, 0);
    step(); req_valid = 2'b00;
    repeat (3) step();

    // Grant statistics: three grants to 0, one to 1
    do_reset();
    setreq(0, 32'd100, 32'd1, ALU_SUB);
    setreq(1, 32'd3, 32'd4, ALU_ADD);
    req_valid = 2'b01; rsp_ready = 2'b11;
    repeat (9) @(negedge clk);
    step(); req_valid = 2'b10;
    @(negedge clk); check("stats_rdy1", req_ready, 2'b10);
    step(); req_valid = 2'b00;
    repeat (3) step();
    check("stats_model0", m_cnt[0], 3);
    check("stats_model1", m_cnt[1], 1);
`ifdef ALU_ARB_STATS_EN
    check("stats_cnt", grant_cnt, {16'd1, 16'd3});
`else
    check("stats_cnt", grant_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
